// File: rtl/tap_clksw_ctrl.sv
// Chip/test clock-select sequencer for the TAP clock multiplexer.
// Optional halt timeout: define TAP_CLKSW_TIMEOUT_EN to add the timeout_o port.
module tap_clksw_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int HALT_TIMEOUT  = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic test_req_i,
  input  logic core_idle_i,
  output logic halt_req_o,
  output logic clk_gate_en_o,
  output logic clksel_o,
  output logic test_ack_o,
  output logic busy_o
`ifdef TAP_CLKSW_TIMEOUT_EN
  ,
  output logic timeout_o
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    FUNC     = 3'd0,
    HALT     = 3'd1,
    GATE_OFF = 3'd2,
    SWITCH   = 3'd3,
    SETTLE   = 3'd4,
    GATE_ON  = 3'd5,
    TEST     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;   // clksel value the running switch ends on
  logic [SYNC_STAGES-1:0] sync_q;
  logic             req_s;

  logic halt_d, gate_d, sel_d, ack_d, busy_d;

`ifdef TAP_CLKSW_TIMEOUT_EN
  localparam int HT_W = $clog2(HALT_TIMEOUT + 1);
  localparam logic [HT_W-1:0] HT_LAST = HT_W'(HALT_TIMEOUT - 1);
  logic [HT_W-1:0] halt_cnt_q, halt_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // test_req_i is asynchronous to clk_i; only the last stage is used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], test_req_i};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
`ifdef TAP_CLKSW_TIMEOUT_EN
    halt_cnt_d = halt_cnt_q;
    timeout_d  = timeout_q;
`endif

    unique case (state_q)
      FUNC: begin
        if (req_s) begin
          state_d  = HALT;
          target_d = 1'b0;
`ifdef TAP_CLKSW_TIMEOUT_EN
          halt_cnt_d = '0;
`endif
        end
      end
      HALT: begin
        if (core_idle_i) begin
          state_d = GATE_OFF;
          cnt_d   = CNT_LOAD;
        end
`ifdef TAP_CLKSW_TIMEOUT_EN
        else if (halt_cnt_q == HT_LAST) begin
          state_d   = GATE_OFF;
          cnt_d     = CNT_LOAD;
          timeout_d = 1'b1;
        end else begin
          halt_cnt_d = halt_cnt_q + HT_W'(1);
        end
`endif
      end
      GATE_OFF: begin
        if (cnt_q == '0) state_d = SWITCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SWITCH: begin
        state_d = SETTLE;
        cnt_d   = CNT_LOAD;
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = GATE_ON;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      GATE_ON: begin
        state_d = target_q ? FUNC : TEST;
      end
      TEST: begin
        // The core is still halted from the entry switch, so HALT is skipped.
        if (!req_s) begin
          state_d  = GATE_OFF;
          target_d = 1'b1;
          cnt_d    = CNT_LOAD;
        end
      end
      default: begin
        state_d = FUNC;
      end
    endcase

    // Moore outputs decoded from the next state, then registered below.
    halt_d = (state_d != FUNC);
    gate_d = !(state_d inside {GATE_OFF, SWITCH, SETTLE});
    ack_d  = (state_d == TEST);
    busy_d = (state_d inside {HALT, GATE_OFF, SWITCH, SETTLE, GATE_ON});
    sel_d  = clksel_o;
    if (state_d == SWITCH)    sel_d = target_q;
    else if (state_d == FUNC) sel_d = 1'b1;
    else if (state_d == TEST) sel_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FUNC;
      cnt_q         <= '0;
      target_q      <= 1'b1;
      halt_req_o    <= 1'b0;
      clk_gate_en_o <= 1'b1;
      clksel_o      <= 1'b1;
      test_ack_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      halt_req_o    <= halt_d;
      clk_gate_en_o <= gate_d;
      clksel_o      <= sel_d;
      test_ack_o    <= ack_d;
      busy_o        <= busy_d;
    end
  end

`ifdef TAP_CLKSW_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halt_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      halt_cnt_q <= halt_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_tap_clksw_ctrl.sv
// Bench for tap_clksw_ctrl: vector table, hand sequences and random traffic vs a timeline model.
`timescale 1ns/1ps
module tb_tap_clksw_ctrl;

  localparam int SYNC = 2;
  localparam int S    = 4;
`ifdef TAP_CLKSW_TIMEOUT_EN
  localparam int HT        = 16;
  localparam int HALT_WAIT = 10;
`else
  localparam int HT        = 255;
  localparam int HALT_WAIT = 50;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_req = 1'b0;
  logic core_idle = 1'b0;
  logic halt_req, clk_gate_en, clksel, test_ack, busy;
  logic timeout;

  always #5 clk = ~clk;

  tap_clksw_ctrl #(
    .SYNC_STAGES  (SYNC),
    .SETTLE_CYCLES(S),
    .HALT_TIMEOUT (HT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .test_req_i   (test_req),
    .core_idle_i  (core_idle),
    .halt_req_o   (halt_req),
    .clk_gate_en_o(clk_gate_en),
    .clksel_o     (clksel),
    .test_ack_o   (test_ack),
    .busy_o       (busy)
`ifdef TAP_CLKSW_TIMEOUT_EN
    ,
    .timeout_o    (timeout)
`endif
  );
`ifndef TAP_CLKSW_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output vector layout: {timeout, halt, gate, sel, ack, busy}
  function automatic logic [5:0] dut_vec();
    return {timeout, halt_req, clk_gate_en, clksel, test_ack, busy};
  endfunction

  // Timeline model: a switch is 2S+2 numbered cycles (S gated, 1 flip, S gated, 1 ungated).
  typedef enum int {M_FUNC, M_HALTING, M_SWITCHING, M_TEST} mode_e;
  mode_e m_mode;
  int    m_k;
  bit    m_to_test;
  int    m_dwell;
  bit    m_timeout;
  bit    m_dl[$];

  task automatic model_reset();
    m_mode = M_FUNC;
    m_k = 0;
    m_to_test = 1'b0;
    m_dwell = 0;
    m_timeout = 1'b0;
    m_dl.delete();
    for (int i = 0; i < SYNC; i++) m_dl.push_back(1'b0);
  endtask

  task automatic model_edge(input bit req, input bit idle);
    bit rs;
    bit start_sw;
    rs = m_dl[0];
    void'(m_dl.pop_front());
    m_dl.push_back(req);
    start_sw = 1'b0;
    case (m_mode)
      M_FUNC: if (rs) begin m_mode = M_HALTING; m_dwell = 0; m_to_test = 1'b1; end
      M_HALTING: begin
        if (idle) start_sw = 1'b1;
`ifdef TAP_CLKSW_TIMEOUT_EN
        else if (m_dwell == HT - 1) begin start_sw = 1'b1; m_timeout = 1'b1; end
`endif
        else m_dwell++;
      end
      M_SWITCHING: begin
        if (m_k == 2 * S + 2) m_mode = m_to_test ? M_TEST : M_FUNC;
        else m_k++;
      end
      M_TEST: if (!rs) begin m_to_test = 1'b0; m_mode = M_SWITCHING; m_k = 1; end
      default: m_mode = M_FUNC;
    endcase
    if (start_sw) begin m_mode = M_SWITCHING; m_k = 1; end
  endtask

  function automatic logic [5:0] model_vec();
    logic h, g, s, a, b, tsel;
    h = (m_mode != M_FUNC);
    g = !(m_mode == M_SWITCHING && m_k <= 2 * S + 1);
    tsel = m_to_test ? 1'b0 : 1'b1;
    case (m_mode)
      M_TEST:      s = 1'b0;
      M_SWITCHING: s = (m_k >= S + 1) ? tsel : !tsel;
      default:     s = 1'b1;
    endcase
    a = (m_mode == M_TEST);
    b = (m_mode == M_HALTING || m_mode == M_SWITCHING);
    return {m_timeout, h, g, s, a, b};
  endfunction

  logic prev_sel, prev_gate;
  int   gate_low_run;

  task automatic clear_monitor();
    prev_sel = 1'b1;
    prev_gate = 1'b1;
    gate_low_run = 0;
  endtask

  // One clock: model advances on the edge, DUT sampled 1 ns later.
  task automatic step();
    logic [5:0] v;
    @(posedge clk);
    model_edge(test_req, core_idle);
    #1;
    v = dut_vec();
    check("model", 8'(v), 8'(model_vec()));
    if (clksel !== prev_sel)
      check("sel_while_gated", {6'd0, prev_gate, clk_gate_en}, 8'd0);
    if (!clk_gate_en) gate_low_run++;
    else if (!prev_gate) begin
      check("gate_low_len", 8'(gate_low_run), 8'(2 * S + 1));
      gate_low_run = 0;
    end
    prev_sel = clksel;
    prev_gate = clk_gate_en;
  endtask

  typedef struct {
    bit         req;
    bit         idle;
    int         n;
    logic [4:0] exp;   // {halt, gate, sel, ack, busy}
    string      name;
  } vec_t;

  localparam logic [4:0] O_FUNC  = 5'b01100;
  localparam logic [4:0] O_HALT  = 5'b11101;
  localparam logic [4:0] O_GOFF1 = 5'b10101;  // gated, sel on chip clock
  localparam logic [4:0] O_GOFF0 = 5'b10001;  // gated, sel on tck
  localparam logic [4:0] O_GON0  = 5'b11001;
  localparam logic [4:0] O_GON1  = 5'b11101;
  localparam logic [4:0] O_TEST  = 5'b11010;

  vec_t vt[27];

  initial begin
    logic [5:0] v;
    int ack_seen;

    vt[0]  = '{0, 1, 20, O_FUNC, "idle_func"};
    vt[1]  = '{1, 1, SYNC, O_FUNC, "entry_sync"};
    vt[2]  = '{1, 1, 1, O_HALT, "entry_halt"};
    vt[3]  = '{1, 1, S, O_GOFF1, "entry_gate_off"};
    vt[4]  = '{1, 1, 1, O_GOFF0, "entry_switch"};
    vt[5]  = '{1, 1, S, O_GOFF0, "entry_settle"};
    vt[6]  = '{1, 1, 1, O_GON0, "entry_gate_on"};
    vt[7]  = '{1, 1, 5, O_TEST, "test_mode"};
    vt[8]  = '{0, 1, SYNC, O_TEST, "return_sync"};
    vt[9]  = '{0, 1, S, O_GOFF0, "return_gate_off"};
    vt[10] = '{0, 1, 1, O_GOFF1, "return_switch"};
    vt[11] = '{0, 1, S, O_GOFF1, "return_settle"};
    vt[12] = '{0, 1, 1, O_GON1, "return_gate_on"};
    vt[13] = '{0, 1, 3, O_FUNC, "return_func"};
    vt[14] = '{1, 0, SYNC, O_FUNC, "wait_sync"};
    vt[15] = '{1, 0, HALT_WAIT, O_HALT, "wait_halt"};
    vt[16] = '{1, 1, S, O_GOFF1, "wait_gate_off"};
    vt[17] = '{1, 1, 1, O_GOFF0, "wait_switch"};
    vt[18] = '{1, 1, S, O_GOFF0, "wait_settle"};
    vt[19] = '{1, 1, 1, O_GON0, "wait_gate_on"};
    vt[20] = '{1, 1, 3, O_TEST, "wait_test"};
    vt[21] = '{0, 1, SYNC, O_TEST, "wret_sync"};
    vt[22] = '{0, 1, S, O_GOFF0, "wret_gate_off"};
    vt[23] = '{0, 1, 1, O_GOFF1, "wret_switch"};
    vt[24] = '{0, 1, S, O_GOFF1, "wret_settle"};
    vt[25] = '{0, 1, 1, O_GON1, "wret_gate_on"};
    vt[26] = '{0, 1, 3, O_FUNC, "wret_func"};

    model_reset();
    clear_monitor();
    #12;
    check("reset_state", 8'(dut_vec()), 8'(6'b001100));
    #5 rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      test_req = vt[i].req;
      core_idle = vt[i].idle;
      for (int c = 0; c < vt[i].n; c++) begin
        step();
        v = dut_vec();
        check(vt[i].name, 8'(v[4:0]), 8'(vt[i].exp));
      end
    end

    // Request dropped mid-SETTLE: the switch still lands in TEST, then returns.
    test_req = 1'b1;
    core_idle = 1'b1;
    repeat (10) step();
    test_req = 1'b0;
    core_idle = 1'b0;   // idle loss after HALT is ignored
    ack_seen = 0;
    repeat (25) begin
      step();
      if (test_ack) ack_seen++;
    end
    check("pulse_reached_test", 8'(ack_seen > 0), 8'd1);
    v = dut_vec();
    check("pulse_back_func", 8'(v[4:0]), 8'(O_FUNC));

`ifdef TAP_CLKSW_TIMEOUT_EN
    test_req = 1'b1;
    core_idle = 1'b0;
    repeat (SYNC + HT) step();
    check("timeout_before", 8'(timeout), 8'd0);
    step();
    check("timeout_set", {6'd0, timeout, clk_gate_en}, 8'b10);
    repeat (2 * S + 6) step();
    check("timeout_in_test", 8'(test_ack), 8'd1);
    test_req = 1'b0;
    repeat (20) step();
    check("timeout_sticky", 8'(timeout), 8'd1);
`endif

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) test_req = ~test_req;
      if ($urandom_range(0, 5) == 0) core_idle = 1'($urandom_range(0, 1));
      step();
    end

    // Asynchronous reset in the middle of SETTLE.
    test_req = 1'b0;
    core_idle = 1'b1;
    repeat (40) step();
    test_req = 1'b1;
    repeat (10) step();
    v = dut_vec();
    check("pre_reset_gated", 8'(v[3]), 8'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 8'(dut_vec()), 8'(6'b001100));
    model_reset();
    clear_monitor();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_req = 1'b0;
    repeat (5) step();
    v = dut_vec();
    check("after_reset_func", 8'(v), 8'(6'b001100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
